// File: rtl/sw_cond_pkg.sv
// -----------------------------------------------------------------------------
// sw_cond_pkg
// Shared definitions for the switch conditioner: the debouncer state type and
// the default configuration constants used by the top and the testbench.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package sw_cond_pkg;

   typedef enum logic {
      IDLE     = 1'b0,
      SETTLING = 1'b1
   } state_t;

   localparam int SW_WIDTH           = 10;
   localparam int SW_SYNC_STAGES     = 2;
   localparam int SW_DEBOUNCE_CYCLES = 8;

endpackage : sw_cond_pkg

// File: rtl/sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
// Multi-flop synchronizer for a bus of asynchronous inputs. Every bit passes
// through STAGES flops in series; q_o is the last stage.
//
// Ports:
//   clk_i  in   system clock, rising edge
//   reset  in   asynchronous, active-low reset (all stages cleared to 0)
//   d_i    in   asynchronous input bus, WIDTH bits
//   q_o    out  synchronized bus, WIDTH bits
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module sync_chain #(
   parameter int WIDTH  = 10,
   parameter int STAGES = 2
) (
   input  logic             clk_i,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   // stage_q[0] is the first (metastability-exposed) stage.
   logic [STAGES-1:0][WIDTH-1:0] stage_q;
   logic [STAGES-1:0][WIDTH-1:0] stage_d;

   always_comb begin
      stage_d = {stage_q[STAGES-2:0], d_i};
   end

   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign q_o = stage_q[STAGES-1];

endmodule : sync_chain

// File: rtl/switch_conditioner.sv
// -----------------------------------------------------------------------------
// switch_conditioner
// Synchronizes and debounces the raw board switch bus and presents the result
// to the processor's switch operand input. Each accepted change raises a held
// change flag that the consumer clears with an acknowledge; a change accepted
// while the flag is still pending sets a sticky overflow flag.
//
// Ports:
//   clk_i           in   system clock, rising edge
//   reset           in   asynchronous, active-low reset
//   switches_raw_i  in   raw asynchronous switch pins, WIDTH bits
//   freeze_i        in   (only with SWITCH_COND_FREEZE_EN) hold outputs steady
//   switches_o      out  debounced stable value, WIDTH bits
//   change_valid_o  out  accepted change pending acknowledge
//   change_ack_i    in   consumer acknowledge
//   change_ovf_o    out  sticky: change accepted while one was still pending
//   busy_o          out  debouncer is settling a candidate value
//
// Build option: define SWITCH_COND_FREEZE_EN to add freeze_i. While frozen the
// debouncer keeps running but publication of a new value (and acknowledges)
// is deferred until the first unfrozen edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module switch_conditioner
   import sw_cond_pkg::*;
#(
   parameter int WIDTH           = SW_WIDTH,
   parameter int SYNC_STAGES     = SW_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
) (
   input  logic             clk_i,
   input  logic             reset,
   input  logic [WIDTH-1:0] switches_raw_i,
`ifdef SWITCH_COND_FREEZE_EN
   input  logic             freeze_i,
`endif
   output logic [WIDTH-1:0] switches_o,
   output logic             change_valid_o,
   input  logic             change_ack_i,
   output logic             change_ovf_o,
   output logic             busy_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync_q;

   state_t           state_q,  state_d;
   logic [WIDTH-1:0] cand_q,   cand_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   // deb_q is the most recently debounced value; stable_q is the value that
   // has been published. They only differ while publication is frozen.
   logic [WIDTH-1:0] deb_q,    deb_d;
   logic [WIDTH-1:0] stable_q, stable_d;
   logic             valid_q,  valid_d;
   logic             ovf_q,    ovf_d;

   logic             publish_ok;
   logic             accept;
   logic             ack_eff;

   sync_chain #(
      .WIDTH  (WIDTH),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i (clk_i),
      .reset (reset),
      .d_i   (switches_raw_i),
      .q_o   (sync_q)
   );

`ifdef SWITCH_COND_FREEZE_EN
   assign publish_ok = ~freeze_i;
`else
   assign publish_ok = 1'b1;
`endif

   // Debouncer: the whole vector settles as one unit.
   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      deb_d   = deb_q;
      unique case (state_q)
         IDLE: begin
            if (sync_q != deb_q) begin
               cand_d  = sync_q;
               cnt_d   = '0;
               state_d = SETTLING;
            end
         end
         SETTLING: begin
            if (sync_q != cand_q) begin
               cand_d = sync_q;
               cnt_d  = '0;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               // A candidate equal to the old value (glitch that returned)
               // leaves deb unchanged, so no event follows.
               deb_d   = cand_q;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Publication and change handshake. Using deb_d lets a fresh acceptance
   // publish on the completion edge itself; a deferred one publishes on the
   // first unfrozen edge.
   always_comb begin
      stable_d = stable_q;
      valid_d  = valid_q;
      ovf_d    = ovf_q;
      accept   = publish_ok && (deb_d != stable_q);
      ack_eff  = publish_ok && change_ack_i && valid_q;

      if (accept) begin
         stable_d = deb_d;
      end

      if (ack_eff) begin
         valid_d = 1'b0;
         ovf_d   = 1'b0;
      end

      if (accept) begin
         valid_d = 1'b1;
         // A simultaneous acknowledge consumes the old event, so no overflow.
         if (valid_q && !ack_eff) begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cand_q   <= '0;
         cnt_q    <= '0;
         deb_q    <= '0;
         stable_q <= '0;
         valid_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         deb_q    <= deb_d;
         stable_q <= stable_d;
         valid_q  <= valid_d;
         ovf_q    <= ovf_d;
      end
   end

   assign switches_o     = stable_q;
   assign change_valid_o = valid_q;
   assign change_ovf_o   = ovf_q;
   assign busy_o         = (state_q == SETTLING);

endmodule : switch_conditioner
